// File: rtl/store_result_checker.sv
// Store-bus monitor for Pipeline_top: decides pass/fail/timeout from data-memory
// writes and keeps a small first-word-fall-through log of the stores it observed.
module store_result_checker #(
   parameter logic [31:0] PASS_ADDR      = 32'd44,
   parameter logic [31:0] PASS_DATA      = 32'hFFFF_FFFD,
   parameter logic [31:0] IGNORE_ADDR    = 32'd96,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned LOG_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [31:0] fail_addr,
   output logic [31:0] fail_data,
   output logic [15:0] store_count,
   output logic [31:0] cycle_count,
   output logic        log_valid,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   input  logic        log_pop,
   output logic        log_overflow
);

   localparam int unsigned AW          = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
   localparam int unsigned PW          = AW + 1;
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic [15:0]       store_count_q, store_count_d;
   logic [31:0]       fail_addr_q, fail_addr_d;
   logic [31:0]       fail_data_q, fail_data_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              timeout_q, timeout_d;
   logic              log_overflow_q, log_overflow_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [31:0]       addr_mem_q [LOG_DEPTH];
   logic [31:0]       addr_mem_d [LOG_DEPTH];
   logic [31:0]       data_mem_q [LOG_DEPTH];
   logic [31:0]       data_mem_d [LOG_DEPTH];

   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;
   logic              fifo_empty;
   logic              fifo_full;
   logic              store_in_run;
   logic              pop_en;
   logic              push_en;
   logic [31:0]       cycle_inc;
   logic              timeout_hit;

   // FIFO occupancy: the extra pointer bit separates full from empty
   always_comb begin
      wr_idx       = wr_ptr_q[AW-1:0];
      rd_idx       = rd_ptr_q[AW-1:0];
      fifo_empty   = (wr_ptr_q == rd_ptr_q);
      fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
      store_in_run = (state_q == S_RUN) && MemWrite;
      pop_en       = log_pop && !fifo_empty;
      push_en      = store_in_run && (!fifo_full || pop_en);
      cycle_inc    = cycle_count_q + 32'd1;
      timeout_hit  = (cycle_inc == TIMEOUT_LIM);
   end

   // Outcome FSM, counters and log bookkeeping
   always_comb begin
      state_d        = state_q;
      cycle_count_d  = cycle_count_q;
      store_count_d  = store_count_q;
      fail_addr_d    = fail_addr_q;
      fail_data_d    = fail_data_q;
      log_overflow_d = log_overflow_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;

      case (state_q)
         S_RUN: begin
            cycle_count_d = cycle_inc;
            if (MemWrite) begin
               if (store_count_q != 16'hFFFF) begin
                  store_count_d = store_count_q + 16'd1;
               end
               if ((DataAdr == PASS_ADDR) && (WriteData == PASS_DATA)) begin
                  state_d = S_PASS;
               end else if (DataAdr != IGNORE_ADDR) begin
                  state_d     = S_FAIL;
                  fail_addr_d = DataAdr;
                  fail_data_d = WriteData;
               end else if (timeout_hit) begin
                  state_d = S_TIMEOUT;
               end
            end else if (timeout_hit) begin
               state_d = S_TIMEOUT;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else if (store_in_run) begin
         log_overflow_d = 1'b1;
      end

      pass_d    = (state_d == S_PASS);
      fail_d    = (state_d == S_FAIL);
      timeout_d = (state_d == S_TIMEOUT);
      done_d    = (state_d != S_RUN);
   end

   // Log storage write port
   always_comb begin
      addr_mem_d = addr_mem_q;
      data_mem_d = data_mem_q;
      if (push_en) begin
         addr_mem_d[wr_idx] = DataAdr;
         data_mem_d[wr_idx] = WriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_RUN;
         cycle_count_q  <= '0;
         store_count_q  <= '0;
         fail_addr_q    <= '0;
         fail_data_q    <= '0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         fail_q         <= 1'b0;
         timeout_q      <= 1'b0;
         log_overflow_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
      end else begin
         state_q        <= state_d;
         cycle_count_q  <= cycle_count_d;
         store_count_q  <= store_count_d;
         fail_addr_q    <= fail_addr_d;
         fail_data_q    <= fail_data_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         fail_q         <= fail_d;
         timeout_q      <= timeout_d;
         log_overflow_q <= log_overflow_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
      end
   end

   // Storage needs no reset; validity comes from the pointers
   always_ff @(posedge clk) begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
   end

   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = timeout_q;
   assign fail_addr    = fail_addr_q;
   assign fail_data    = fail_data_q;
   assign store_count  = store_count_q;
   assign cycle_count  = cycle_count_q;
   assign log_overflow = log_overflow_q;
   assign log_valid    = !fifo_empty;
   assign log_addr     = fifo_empty ? 32'd0 : addr_mem_q[rd_idx];
   assign log_data     = fifo_empty ? 32'd0 : data_mem_q[rd_idx];

endmodule

// File: tb/tb_store_result_checker.sv
// Bench for store_result_checker: directed store sequences checked every cycle
// against an outcome/queue model, plus literal expectations at key points.
module tb_store_result_checker;

   localparam int unsigned TO    = 20;
   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] M3    = 32'hFFFF_FFFD;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        log_pop;
   logic        done, pass, fail, timeout;
   logic [31:0] fail_addr, fail_data;
   logic [15:0] store_count;
   logic [31:0] cycle_count;
   logic        log_valid;
   logic [31:0] log_addr, log_data;
   logic        log_overflow;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   store_result_checker #(
      .TIMEOUT_CYCLES(TO),
      .LOG_DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .fail_addr   (fail_addr),
      .fail_data   (fail_data),
      .store_count (store_count),
      .cycle_count (cycle_count),
      .log_valid   (log_valid),
      .log_addr    (log_addr),
      .log_data    (log_data),
      .log_pop     (log_pop),
      .log_overflow(log_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outcome 0=run 1=pass 2=fail 3=timeout, log as a queue of {addr,data}
   int unsigned m_res;
   int unsigned m_cycles;
   int unsigned m_stores;
   logic [31:0] m_faddr, m_fdata;
   logic        m_ovf;
   logic [63:0] m_log[$];
   logic [63:0] m_head;
   bit          m_ok = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_res = 0; m_cycles = 0; m_stores = 0;
         m_faddr = 0; m_fdata = 0; m_ovf = 1'b0;
         m_log.delete();
         m_ok = 1'b1;
      end else begin
         if (log_pop && m_log.size() > 0) void'(m_log.pop_front());
         if (m_res == 0) begin
            m_cycles++;
            if (MemWrite) begin
               if (m_stores < 65535) m_stores++;
               if (m_log.size() < DEPTH) m_log.push_back({DataAdr, WriteData});
               else m_ovf = 1'b1;
               if (DataAdr == 32'd44 && WriteData == M3) m_res = 1;
               else if (DataAdr != 32'd96) begin
                  m_res = 2; m_faddr = DataAdr; m_fdata = WriteData;
               end
            end
            if (m_res == 0 && m_cycles == TO) m_res = 3;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         m_head = (m_log.size() > 0) ? m_log[0] : 64'd0;
         chk("done",         32'(done),         32'(m_res != 0));
         chk("pass",         32'(pass),         32'(m_res == 1));
         chk("fail",         32'(fail),         32'(m_res == 2));
         chk("timeout",      32'(timeout),      32'(m_res == 3));
         chk("fail_addr",    fail_addr,         m_faddr);
         chk("fail_data",    fail_data,         m_fdata);
         chk("store_count",  32'(store_count),  m_stores);
         chk("cycle_count",  cycle_count,       m_cycles);
         chk("log_valid",    32'(log_valid),    32'(m_log.size() > 0));
         chk("log_addr",     log_addr,          m_head[63:32]);
         chk("log_data",     log_data,          m_head[31:0]);
         chk("log_overflow", 32'(log_overflow), 32'(m_ovf));
      end
   end

   task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic pop);
      MemWrite = mw; DataAdr = a; WriteData = d; log_pop = pop;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; log_pop = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // Pass run with benign stores and in-order readback
      do_reset(3);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(log_valid), 32'd0);
      chk("rst_cycles", cycle_count, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
      cyc(1'b1, 32'd96, 32'd7, 1'b0);
      cyc(1'b1, 32'd96, 32'd9, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
      cyc(1'b1, 32'd44, M3, 1'b0);
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_fail", 32'(fail), 32'd0);
      chk("t1_stores", 32'(store_count), 32'd3);
      chk("t1_cycles", cycle_count, 32'd5);
      chk("t1_head0", log_data, 32'd7);
      cyc(1'b0, 32'd0, 32'd0, 1'b1);
      chk("t1_head1", log_data, 32'd9);
      cyc(1'b0, 32'd0, 32'd0, 1'b1);
      chk("t1_head2a", log_addr, 32'd44);
      chk("t1_head2d", log_data, M3);
      cyc(1'b0, 32'd0, 32'd0, 1'b1);
      chk("t1_empty", 32'(log_valid), 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b1);

      // Wrong data at the pass address fails; later stores are ignored
      do_reset(1);
      cyc(1'b1, 32'd44, 32'd5, 1'b0);
      chk("t2_fail", 32'(fail), 32'd1);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_faddr", fail_addr, 32'd44);
      chk("t2_fdata", fail_data, 32'd5);
      cyc(1'b1, 32'd44, M3, 1'b0);
      chk("t2_nopass", 32'(pass), 32'd0);
      chk("t2_stores", 32'(store_count), 32'd1);

      // Stray address fails and is logged
      do_reset(1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
      cyc(1'b1, 32'd100, 32'd1, 1'b0);
      chk("t3_faddr", fail_addr, 32'd100);
      chk("t3_loga", log_addr, 32'd100);
      chk("t3_logd", log_data, 32'd1);
      cyc(1'b0, 32'd0, 32'd0, 1'b1);
      chk("t3_empty", 32'(log_valid), 32'd0);

      // Idle run times out, then a pass store is ignored
      do_reset(1);
      repeat (TO - 1) cyc(1'b0, 32'd0, 32'd0, 1'b0);
      chk("t4_notyet", 32'(timeout), 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
      chk("t4_timeout", 32'(timeout), 32'd1);
      chk("t4_cycles", cycle_count, 32'd20);
      cyc(1'b1, 32'd44, M3, 1'b0);
      chk("t4_nopass", 32'(pass), 32'd0);
      chk("t4_frozen", cycle_count, 32'd20);

      // Pass store on the timeout edge wins
      do_reset(1);
      repeat (TO - 1) cyc(1'b0, 32'd0, 32'd0, 1'b0);
      cyc(1'b1, 32'd44, M3, 1'b0);
      chk("t5_pass", 32'(pass), 32'd1);
      chk("t5_timeout", 32'(timeout), 32'd0);

      // Overflow, pop+push on full, then reset mid-stream
      do_reset(1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'd96, 32'(i), 1'b0);
      chk("t6_ovf", 32'(log_overflow), 32'd1);
      chk("t6_stores", 32'(store_count), 32'd10);
      chk("t6_head", log_data, 32'd0);
      cyc(1'b1, 32'd96, 32'hA5, 1'b1);
      chk("t6_head_after", log_data, 32'd1);
      chk("t6_ovf_sticky", 32'(log_overflow), 32'd1);
      reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'd96; WriteData = 32'h55; log_pop = 1'b0;
      @(negedge clk);
      reset = 1'b0; MemWrite = 1'b0;
      chk("t6_rst_valid", 32'(log_valid), 32'd0);
      chk("t6_rst_ovf", 32'(log_overflow), 32'd0);
      chk("t6_rst_stores", 32'(store_count), 32'd0);
      chk("t6_rst_addr", log_addr, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
